rx_window_controller: RTL and testbench

//  Sequences the tag-response receive path around preamble_detector. Each reader command opens one window:

---
 rtl/rx_ctrl_pkg.sv | 18 +
 rtl/rx_timer.sv | 28 ++
 rtl/rx_window_controller.sv | 157 +++++++++++++++
 tb/tb_rx_window_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared encodings for the receive-window controller: FSM states and the
// status codes reported with rx_done.
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLDOFF = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] STATUS_OK          = 2'd0;
    localparam logic [1:0] STATUS_NO_PREAMBLE = 2'd1;
    localparam logic [1:0] STATUS_OVERFLOW    = 2'd2;
    localparam logic [1:0] STATUS_ABORTED     = 2'd3;

endpackage

// File: rtl/rx_timer.sv
// Loadable down-counter. A load of N-1 makes expired rise after N cycles in
// the loaded state; the count parks at zero instead of wrapping.
module rx_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rx_window_controller.sv
// Receive-window sequencer around the preamble detector. One window per
// tx_done: holdoff with the detector in reset, preamble search under a
// timeout, bit forwarding until postamble/overflow/abort, one status pulse.
// Handshake: rx_vld is a one-cycle qualifier for rx_dat with no backpressure;
// rx_done is a one-cycle pulse qualifying rx_status, rx_bit_count, rx_bank.
module rx_window_controller
    import rx_ctrl_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 64,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int MAX_BITS       = 128,
    parameter int BANKS          = 9,
    localparam int CW            = $clog2(MAX_BITS + 1),
    localparam int BANK_WIDTH    = $clog2(BANKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_done,
    input  logic                  abort,
    input  logic [CW-1:0]         max_bits,
    input  logic                  det_out_dat,
    input  logic                  det_out_vld,
    input  logic                  det_preamble,
    input  logic                  det_postamble,
    input  logic [BANK_WIDTH-1:0] det_bank,
    output logic                  det_rst,
    output logic                  det_en,
    output logic                  rx_dat,
    output logic                  rx_vld,
    output logic                  rx_done,
    output logic [1:0]            rx_status,
    output logic [CW-1:0]         rx_bit_count,
    output logic [BANK_WIDTH-1:0] rx_bank,
    output logic                  busy
);

    localparam int TMAX = (SEARCH_TIMEOUT > HOLDOFF_CYCLES) ? SEARCH_TIMEOUT : HOLDOFF_CYCLES;
    localparam int TW   = $clog2(TMAX);

    state_t          state;
    logic [CW-1:0]   max_bits_q;
    logic            timer_load;
    logic [TW-1:0]   timer_val;
    logic            timer_expired;
    logic            close;
    logic [1:0]      close_status;

    // Timer reload: holdoff length on window open, search length on holdoff expiry.
    always_comb begin
        timer_load = ((state == ST_IDLE) && tx_done) ||
                     ((state == ST_HOLDOFF) && timer_expired);
        timer_val  = (state == ST_IDLE) ? TW'(HOLDOFF_CYCLES - 1) : TW'(SEARCH_TIMEOUT - 1);
    end

    rx_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Window-closing conditions in priority order: abort, then per-state causes.
    // A preamble in the timeout cycle keeps the window open.
    always_comb begin
        close        = 1'b0;
        close_status = STATUS_OK;
        if (abort && (state == ST_HOLDOFF || state == ST_SEARCH || state == ST_RECEIVE)) begin
            close        = 1'b1;
            close_status = STATUS_ABORTED;
        end else if (state == ST_SEARCH) begin
            if (!det_preamble && timer_expired) begin
                close        = 1'b1;
                close_status = STATUS_NO_PREAMBLE;
            end
        end else if (state == ST_RECEIVE) begin
            if (det_postamble) begin
                close        = 1'b1;
                close_status = STATUS_OK;
            end else if (det_out_vld && (rx_bit_count == max_bits_q)) begin
                close        = 1'b1;
                close_status = STATUS_OVERFLOW;
            end
        end
    end

    // Window FSM with registered outputs; rx_vld and rx_done are one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            max_bits_q   <= '0;
            det_rst      <= 1'b1;
            det_en       <= 1'b0;
            rx_dat       <= 1'b0;
            rx_vld       <= 1'b0;
            rx_done      <= 1'b0;
            rx_status    <= STATUS_OK;
            rx_bit_count <= '0;
            rx_bank      <= '0;
            busy         <= 1'b0;
        end else begin
            rx_vld  <= 1'b0;
            rx_done <= 1'b0;
            if (close) begin
                state     <= ST_DONE;
                rx_status <= close_status;
                rx_done   <= 1'b1;
                det_rst   <= 1'b1;
                det_en    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_done) begin
                            state        <= ST_HOLDOFF;
                            max_bits_q   <= max_bits;
                            rx_bit_count <= '0;
                            rx_bank      <= '0;
                            rx_status    <= STATUS_OK;
                            busy         <= 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (timer_expired) begin
                            state   <= ST_SEARCH;
                            det_rst <= 1'b0;
                            det_en  <= 1'b1;
                        end
                    end
                    ST_SEARCH: begin
                        if (det_preamble) begin
                            state   <= ST_RECEIVE;
                            rx_bank <= det_bank;
                        end
                    end
                    ST_RECEIVE: begin
                        if (det_out_vld && (rx_bit_count != '1)) begin
                            rx_vld       <= 1'b1;
                            rx_dat       <= det_out_dat;
                            rx_bit_count <= rx_bit_count + CW'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        det_rst <= 1'b1;
                        det_en  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_window_controller.sv
// Directed bench for rx_window_controller. Inputs change on the falling
// edge, outputs are sampled on the falling edge after the rising edge that
// consumed them.
module tb_rx_window_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_done;
    logic       abort;
    logic [7:0] max_bits;
    logic       det_out_dat;
    logic       det_out_vld;
    logic       det_preamble;
    logic       det_postamble;
    logic [3:0] det_bank;
    logic       det_rst;
    logic       det_en;
    logic       rx_dat;
    logic       rx_vld;
    logic       rx_done;
    logic [1:0] rx_status;
    logic [7:0] rx_bit_count;
    logic [3:0] rx_bank;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    rx_window_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_done       (tx_done),
        .abort         (abort),
        .max_bits      (max_bits),
        .det_out_dat   (det_out_dat),
        .det_out_vld   (det_out_vld),
        .det_preamble  (det_preamble),
        .det_postamble (det_postamble),
        .det_bank      (det_bank),
        .det_rst       (det_rst),
        .det_en        (det_en),
        .rx_dat        (rx_dat),
        .rx_vld        (rx_vld),
        .rx_done       (rx_done),
        .rx_status     (rx_status),
        .rx_bit_count  (rx_bit_count),
        .rx_bank       (rx_bank),
        .busy          (busy)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse tx_done and follow the holdoff: detector held for 64 cycles,
    // released on the 65th falling edge. Leaves the DUT 64 cycles past tx_done.
    task automatic open_window(input string tag, input logic [7:0] mb);
        max_bits = mb;
        tx_done  = 1'b1;
        tick(1);
        tx_done  = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold_rst"}, det_rst, 1);
        tick(63);
        chk({tag, "_hold_end_rst"}, det_rst, 1);
        chk({tag, "_hold_end_en"}, det_en, 0);
        tick(1);
        chk({tag, "_search_rst"}, det_rst, 0);
        chk({tag, "_search_en"}, det_en, 1);
    endtask

    task automatic preamble(input string tag, input logic [3:0] bank);
        det_preamble = 1'b1;
        det_bank     = bank;
        tick(1);
        det_preamble = 1'b0;
        det_bank     = 4'd0;
        chk({tag, "_bank"}, rx_bank, bank);
    endtask

    task automatic send_bit(input string tag, input logic b, input logic fwd);
        det_out_vld = 1'b1;
        det_out_dat = b;
        tick(1);
        det_out_vld = 1'b0;
        det_out_dat = 1'b0;
        chk({tag, "_vld"}, rx_vld, fwd);
        if (fwd) chk({tag, "_dat"}, rx_dat, b);
    endtask

    initial begin
        int n;
        logic [4:0] pattern;

        rst_n         = 1'b0;
        tx_done       = 1'b0;
        abort         = 1'b0;
        max_bits      = 8'd0;
        det_out_dat   = 1'b0;
        det_out_vld   = 1'b0;
        det_preamble  = 1'b0;
        det_postamble = 1'b0;
        det_bank      = 4'd0;

        // Reset values
        tick(2);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_en", det_en, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_rx_done", rx_done, 0);
        chk("rst_rx_dat", rx_dat, 0);
        chk("rst_status", rx_status, 0);
        chk("rst_count", rx_bit_count, 0);
        chk("rst_bank", rx_bank, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: preamble at search cycle 100, bits 10110, postamble -> OK
        open_window("t1", 8'd10);
        tick(100);
        preamble("t1_pre", 4'd6);
        pattern = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            send_bit("t1_bit", pattern[i], 1'b1);
        end
        chk("t1_count_live", rx_bit_count, 5);
        det_postamble = 1'b1;
        tick(1);
        det_postamble = 1'b0;
        chk("t1_done", rx_done, 1);
        chk("t1_no_vld", rx_vld, 0);
        chk("t1_status", rx_status, 0);
        chk("t1_count", rx_bit_count, 5);
        chk("t1_bank", rx_bank, 6);
        tick(1);
        chk("t1_done_pulse", rx_done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_rst", det_rst, 1);
        chk("t1_count_held", rx_bit_count, 5);

        // 2: no preamble -> NO_PREAMBLE 64+4096 cycles after tx_done
        open_window("t2", 8'd10);
        n = 64;
        while (!rx_done && n < 5000) begin
            tick(1);
            n++;
        end
        checks++;
        assert (n >= 4159 && n <= 4161) else begin
            failures++;
            $error("FAIL t2_latency observed=%0d expected=4160", n);
        end
        chk("t2_done", rx_done, 1);
        chk("t2_status", rx_status, 1);
        chk("t2_count", rx_bit_count, 0);
        chk("t2_det_en", det_en, 0);
        tick(1);
        chk("t2_busy", busy, 0);

        // 3: max_bits=3, fourth bit overflows and is not forwarded
        open_window("t3", 8'd3);
        tick(5);
        preamble("t3_pre", 4'd4);
        send_bit("t3_b0", 1'b1, 1'b1);
        send_bit("t3_b1", 1'b1, 1'b1);
        send_bit("t3_b2", 1'b0, 1'b1);
        send_bit("t3_b3", 1'b1, 1'b0);
        chk("t3_done", rx_done, 1);
        chk("t3_status", rx_status, 2);
        chk("t3_count", rx_bit_count, 3);
        tick(1);
        chk("t3_busy", busy, 0);

        // 4: abort after two bits, concurrent bit dropped, no later rx_vld
        open_window("t4", 8'd10);
        preamble("t4_pre", 4'd8);
        send_bit("t4_b0", 1'b0, 1'b1);
        send_bit("t4_b1", 1'b1, 1'b1);
        abort       = 1'b1;
        det_out_vld = 1'b1;
        det_out_dat = 1'b1;
        tick(1);
        abort       = 1'b0;
        chk("t4_no_vld", rx_vld, 0);
        chk("t4_done", rx_done, 1);
        chk("t4_status", rx_status, 3);
        chk("t4_count", rx_bit_count, 2);
        tick(1);
        det_out_vld = 1'b0;
        det_out_dat = 1'b0;
        chk("t4_idle_vld", rx_vld, 0);
        chk("t4_busy", busy, 0);

        // 5: preamble in the timeout cycle wins; postamble drops concurrent bit
        open_window("t5", 8'd10);
        tick(4095);
        preamble("t5_pre", 4'd2);
        chk("t5_no_done", rx_done, 0);
        chk("t5_busy", busy, 1);
        chk("t5_det_en", det_en, 1);
        send_bit("t5_b0", 1'b1, 1'b1);
        det_postamble = 1'b1;
        det_out_vld   = 1'b1;
        det_out_dat   = 1'b1;
        tick(1);
        det_postamble = 1'b0;
        det_out_vld   = 1'b0;
        det_out_dat   = 1'b0;
        chk("t5_drop_vld", rx_vld, 0);
        chk("t5_done", rx_done, 1);
        chk("t5_status", rx_status, 0);
        chk("t5_count", rx_bit_count, 1);
        tick(1);

        // 6a: tx_done during HOLDOFF neither restarts nor relatches max_bits
        max_bits = 8'd2;
        tx_done  = 1'b1;
        tick(1);
        tx_done  = 1'b0;
        tick(10);
        max_bits = 8'd10;
        tx_done  = 1'b1;
        tick(1);
        tx_done  = 1'b0;
        tick(52);
        chk("t6_hold_en", det_en, 0);
        tick(1);
        chk("t6_search_en", det_en, 1);
        preamble("t6_pre", 4'd1);
        send_bit("t6_b0", 1'b1, 1'b1);
        send_bit("t6_b1", 1'b1, 1'b1);
        send_bit("t6_b2", 1'b0, 1'b0);
        chk("t6_status", rx_status, 2);
        chk("t6_count", rx_bit_count, 2);
        tick(1);

        // 6b: asynchronous reset in SEARCH
        open_window("t6r", 8'd5);
        tick(20);
        rst_n = 1'b0;
        #1;
        chk("t6r_det_rst", det_rst, 1);
        chk("t6r_det_en", det_en, 0);
        chk("t6r_busy", busy, 0);
        chk("t6r_done", rx_done, 0);
        chk("t6r_vld", rx_vld, 0);
        chk("t6r_status", rx_status, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("t6r_stay_idle", busy, 0);
        chk("t6r_stay_rst", det_rst, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
